// File: rtl/divider_block_pkg.sv
// Shared encodings and sizing for the iterative divider.
// The op encoding, FSM states and step count are kept here for use by the top and its step datapath.
package divider_block_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int STEPS     = 32;
  localparam int CNT_W     = $clog2(STEPS) + 1;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  function automatic logic [DEF_WIDTH-1:0] neg_if(input logic [DEF_WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

endpackage

// File: rtl/divider_block_step.sv
// One restoring-division step: shift in the next dividend bit, then trial-subtract the divisor.
module divider_step
  import divider_block_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < dvs holds between steps, so the borrow bit alone decides the quotient bit
  always_comb begin
    shifted = {rem, dvd_msb};
    diff    = shifted - {1'b0, dvs};
    q_bit   = ~diff[WIDTH];
    rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_block.sv
// Fixed-latency 32-step restoring divider for DIV/DIVU/REM/REMU, with clock enable and
// synchronous active-low reset.
module divider_block
  import divider_block_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK_0,
  input  logic             RSTN_0,
  input  logic             CE_0,
  input  logic             START_0,
  input  logic [1:0]       OP_0,
  input  logic [WIDTH-1:0] A_0,
  input  logic [WIDTH-1:0] B_0,
  output logic             BUSY_0,
  output logic             DONE_0,
  output logic [WIDTH-1:0] P_0
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  op_e              op_q;
  logic             a_neg_q, b_neg_q, dz_q;
  logic [WIDTH-1:0] a_raw_q, dvs_q, rem_q, quo_q, p_q;
  logic             done_q;

  op_e              op_in;
  logic             signed_in, start_go, last_step;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic             is_signed, is_rem;
  logic [WIDTH-1:0] q_fix, r_fix, res;

  assign op_in     = op_e'(OP_0);
  assign signed_in = (op_in == OP_DIV) || (op_in == OP_REM);
  assign start_go  = (state_q == ST_IDLE) && START_0;
  assign last_step = (cnt_q == CNT_W'(STEPS - 1));

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .dvd_msb (quo_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge CLK_0) begin
    if (!RSTN_0)   state_q <= ST_IDLE;
    else if (CE_0) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START_0) state_d = ST_CALC;
      ST_CALC: if (last_step) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY_0 = (state_q != ST_IDLE);
  end

  // Sign fix-up; divide-by-zero overrides it. Overflow (MIN / -1) falls out of the negation naturally.
  always_comb begin
    is_signed = (op_q == OP_DIV) || (op_q == OP_REM);
    is_rem    = (op_q == OP_REM) || (op_q == OP_REMU);
    q_fix     = neg_if(quo_q, is_signed & (a_neg_q ^ b_neg_q));
    r_fix     = neg_if(rem_q, is_signed & a_neg_q);
    if (dz_q) begin
      q_fix = '1;
      r_fix = a_raw_q;
    end
    res = is_rem ? r_fix : q_fix;
  end

  always_ff @(posedge CLK_0) begin
    if (!RSTN_0) begin
      cnt_q   <= '0;
      op_q    <= OP_DIV;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      a_raw_q <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else if (CE_0) begin
      done_q <= (state_q == ST_FIN);
      if (start_go) begin
        op_q    <= op_in;
        a_neg_q <= signed_in & A_0[WIDTH-1];
        b_neg_q <= signed_in & B_0[WIDTH-1];
        dz_q    <= (B_0 == '0);
        a_raw_q <= A_0;
        quo_q   <= neg_if(A_0, signed_in & A_0[WIDTH-1]);
        dvs_q   <= neg_if(B_0, signed_in & B_0[WIDTH-1]);
        rem_q   <= '0;
        cnt_q   <= '0;
      end else if (state_q == ST_CALC) begin
        rem_q <= rem_nxt;
        quo_q <= {quo_q[WIDTH-2:0], q_bit};
        cnt_q <= cnt_q + 1'b1;
      end else if (state_q == ST_FIN) begin
        p_q <= res;
      end
    end
  end

  assign DONE_0 = done_q;
  assign P_0    = p_q;

endmodule

// File: tb/tb_divider_block.sv
// Directed bench for divider_block: results, latency, handshake, clock-enable and reset behaviour.
module tb_divider_block;

  logic        CLK_0;
  logic        RSTN_0;
  logic        CE_0;
  logic        START_0;
  logic [1:0]  OP_0;
  logic [31:0] A_0;
  logic [31:0] B_0;
  logic        BUSY_0;
  logic        DONE_0;
  logic [31:0] P_0;

  int n_chk  = 0;
  int n_pass = 0;

  divider_block #(.WIDTH(32)) dut (
    .CLK_0   (CLK_0),
    .RSTN_0  (RSTN_0),
    .CE_0    (CE_0),
    .START_0 (START_0),
    .OP_0    (OP_0),
    .A_0     (A_0),
    .B_0     (B_0),
    .BUSY_0  (BUSY_0),
    .DONE_0  (DONE_0),
    .P_0     (P_0)
  );

  initial CLK_0 = 1'b0;
  always #5 CLK_0 = ~CLK_0;

  // Issues one request from just after an edge; returns edges-to-DONE (-1 on timeout), BUSY cycles, result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n, output logic [31:0] res);
    START_0 = 1'b1; OP_0 = op; A_0 = a; B_0 = b;
    @(posedge CLK_0); #1;
    START_0 = 1'b0; OP_0 = 2'b11; A_0 = 32'hDEAD_BEEF; B_0 = 32'h0000_0003;
    lat = 0; busy_n = BUSY_0 ? 1 : 0; res = '0;
    while (lat < 100) begin
      @(posedge CLK_0); #1;
      lat++;
      if (BUSY_0) busy_n++;
      if (DONE_0) begin
        res = P_0;
        break;
      end
    end
    if (!DONE_0) lat = -1;
  endtask

  task automatic test_reset();
    RSTN_0 = 1'b0; CE_0 = 1'b1; START_0 = 1'b0; OP_0 = 2'b00; A_0 = '0; B_0 = '0;
    repeat (2) @(posedge CLK_0);
    #1;
    n_chk++; if (BUSY_0 !== 1'b0) $display("FAIL reset_busy: got %0b want 0", BUSY_0); else n_pass++;
    n_chk++; if (DONE_0 !== 1'b0) $display("FAIL reset_done: got %0b want 0", DONE_0); else n_pass++;
    n_chk++; if (P_0 !== 32'h0) $display("FAIL reset_p: got %h want 00000000", P_0); else n_pass++;
    RSTN_0 = 1'b1;
    @(posedge CLK_0); #1;
  endtask

  task automatic test_divu_remu();
    int lat, bn; logic [31:0] r;
    run_op(2'b01, 32'd100, 32'd7, lat, bn, r);
    n_chk++; if (lat !== 33) $display("FAIL divu_latency: got %0d want 33", lat); else n_pass++;
    n_chk++; if (bn !== 33) $display("FAIL divu_busy_cycles: got %0d want 33", bn); else n_pass++;
    n_chk++; if (r !== 32'd14) $display("FAIL divu_result: got %h want 0000000e", r); else n_pass++;
    @(posedge CLK_0); #1;
    n_chk++; if (DONE_0 !== 1'b0) $display("FAIL divu_done_pulse: got %0b want 0", DONE_0); else n_pass++;
    n_chk++; if (P_0 !== 32'd14) $display("FAIL divu_p_hold: got %h want 0000000e", P_0); else n_pass++;
    run_op(2'b11, 32'd100, 32'd7, lat, bn, r);
    n_chk++; if (r !== 32'd2) $display("FAIL remu_result: got %h want 00000002", r); else n_pass++;
  endtask

  task automatic test_signed();
    int lat, bn; logic [31:0] r;
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, lat, bn, r);
    n_chk++; if (r !== 32'hFFFF_FFFD) $display("FAIL div_neg_result: got %h want fffffffd", r); else n_pass++;
    n_chk++; if (lat !== 33) $display("FAIL div_neg_latency: got %0d want 33", lat); else n_pass++;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bn, r);
    n_chk++; if (r !== 32'hFFFF_FFFF) $display("FAIL rem_neg_result: got %h want ffffffff", r); else n_pass++;
    run_op(2'b00, 32'd100, 32'hFFFF_FFF9, lat, bn, r);
    n_chk++; if (r !== 32'hFFFF_FFF2) $display("FAIL div_negdiv_result: got %h want fffffff2", r); else n_pass++;
  endtask

  task automatic test_div_zero();
    int lat, bn; logic [31:0] r;
    run_op(2'b00, 32'd5, 32'd0, lat, bn, r);
    n_chk++; if (r !== 32'hFFFF_FFFF) $display("FAIL dz_div_pos: got %h want ffffffff", r); else n_pass++;
    n_chk++; if (lat !== 33) $display("FAIL dz_latency: got %0d want 33", lat); else n_pass++;
    run_op(2'b00, 32'hFFFF_FFFB, 32'd0, lat, bn, r);
    n_chk++; if (r !== 32'hFFFF_FFFF) $display("FAIL dz_div_neg: got %h want ffffffff", r); else n_pass++;
    run_op(2'b11, 32'd5, 32'd0, lat, bn, r);
    n_chk++; if (r !== 32'd5) $display("FAIL dz_remu: got %h want 00000005", r); else n_pass++;
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, lat, bn, r);
    n_chk++; if (r !== 32'hFFFF_FFFB) $display("FAIL dz_rem_neg: got %h want fffffffb", r); else n_pass++;
  endtask

  task automatic test_overflow();
    int lat, bn; logic [31:0] r;
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn, r);
    n_chk++; if (r !== 32'h8000_0000) $display("FAIL ovf_div: got %h want 80000000", r); else n_pass++;
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn, r);
    n_chk++; if (r !== 32'h0) $display("FAIL ovf_rem: got %h want 00000000", r); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int n_done, first_lat; logic [31:0] r;
    n_done = 0; first_lat = -1; r = '0;
    START_0 = 1'b1; OP_0 = 2'b01; A_0 = 32'd100; B_0 = 32'd7;
    @(posedge CLK_0); #1;
    START_0 = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      START_0 = (i == 5); A_0 = 32'd1000; B_0 = 32'd1;
      @(posedge CLK_0); #1;
      if (DONE_0) begin
        n_done++;
        if (first_lat < 0) begin first_lat = i; r = P_0; end
      end
    end
    START_0 = 1'b0;
    n_chk++; if (n_done !== 1) $display("FAIL ignore_done_count: got %0d want 1", n_done); else n_pass++;
    n_chk++; if (r !== 32'd14) $display("FAIL ignore_result: got %h want 0000000e", r); else n_pass++;
    n_chk++; if (first_lat !== 33) $display("FAIL ignore_latency: got %0d want 33", first_lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, bn; logic [31:0] r;
    run_op(2'b01, 32'd1000, 32'd10, lat, bn, r);
    n_chk++; if (r !== 32'd100) $display("FAIL b2b_first: got %h want 00000064", r); else n_pass++;
    run_op(2'b11, 32'd1003, 32'd10, lat, bn, r);
    n_chk++; if (lat !== 33) $display("FAIL b2b_latency: got %0d want 33", lat); else n_pass++;
    n_chk++; if (r !== 32'd3) $display("FAIL b2b_second: got %h want 00000003", r); else n_pass++;
  endtask

  task automatic test_ce_stall();
    int lat; logic [31:0] r;
    START_0 = 1'b1; OP_0 = 2'b01; A_0 = 32'd1000; B_0 = 32'd9;
    @(posedge CLK_0); #1;
    START_0 = 1'b0;
    lat = 0; r = '0;
    while (lat < 100) begin
      if (lat == 10) CE_0 = 1'b0;
      if (lat == 15) CE_0 = 1'b1;
      @(posedge CLK_0); #1;
      lat++;
      if (DONE_0) begin r = P_0; break; end
    end
    if (!DONE_0) lat = -1;
    n_chk++; if (lat !== 38) $display("FAIL ce_latency: got %0d want 38", lat); else n_pass++;
    n_chk++; if (r !== 32'd111) $display("FAIL ce_result: got %h want 0000006f", r); else n_pass++;
    CE_0 = 1'b0;
    repeat (3) @(posedge CLK_0);
    #1;
    n_chk++; if (DONE_0 !== 1'b1) $display("FAIL ce_done_hold: got %0b want 1", DONE_0); else n_pass++;
    n_chk++; if (P_0 !== 32'd111) $display("FAIL ce_p_hold: got %h want 0000006f", P_0); else n_pass++;
    CE_0 = 1'b1;
    @(posedge CLK_0); #1;
    n_chk++; if (DONE_0 !== 1'b0) $display("FAIL ce_done_release: got %0b want 0", DONE_0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n_done;
    START_0 = 1'b1; OP_0 = 2'b01; A_0 = 32'd500; B_0 = 32'd3;
    @(posedge CLK_0); #1;
    START_0 = 1'b0;
    repeat (10) @(posedge CLK_0);
    #1;
    RSTN_0 = 1'b0; CE_0 = 1'b0;
    @(posedge CLK_0); #1;
    n_chk++; if (BUSY_0 !== 1'b0) $display("FAIL rst_mid_busy: got %0b want 0", BUSY_0); else n_pass++;
    n_chk++; if (P_0 !== 32'h0) $display("FAIL rst_mid_p: got %h want 00000000", P_0); else n_pass++;
    RSTN_0 = 1'b1; CE_0 = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK_0); #1;
      if (DONE_0) n_done++;
    end
    n_chk++; if (n_done !== 0) $display("FAIL rst_mid_no_done: got %0d want 0", n_done); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_divu_remu();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_ce_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/divider_block.md
DIVIDER_BLOCK -- requirements
Module: divider_block

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width; only 32 is supported.
REQ-002 SHALL have CLK_0 input, 1 bit: the single clock, rising-edge.
REQ-003 SHALL have RSTN_0 input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have CE_0 input, 1 bit: clock enable; when low, all state is frozen.
REQ-005 SHALL have START_0 input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have OP_0 input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have A_0 input, 32 bits: dividend.
REQ-008 SHALL have B_0 input, 32 bits: divisor.
REQ-009 SHALL have BUSY_0 output, 1 bit: high while an operation is in flight.
REQ-010 SHALL have DONE_0 output, 1 bit: one-cycle result-valid pulse.
REQ-011 SHALL have P_0 output, 32 bits: registered result, held until the next DONE_0.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and FIN.
REQ-013 On an edge with CE_0=1, IDLE and START_0=1, the block SHALL:
- capture OP_0;
- capture the absolute values of A_0 and B_0 (signed ops) or the raw values (unsigned ops);
- capture the sign flags, and the div-by-zero flag (B_0==0);
- clear the iteration counter;
- enter CALC.
REQ-014 Each CE_0-enabled edge in CALC SHALL perform one restoring step: shift the remainder left by one bit, bringing in the next dividend MSB, then compare-subtract the divisor and shift in one quotient bit.
REQ-015 After 32 steps the FSM SHALL move to FIN.
REQ-016 The FIN edge SHALL write P_0, assert DONE_0 and return to IDLE.
REQ-017 Sign correction in FIN:
- quotient SHALL be negated when the dividend and divisor signs differ;
- remainder SHALL take the dividend's sign.
REQ-018 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder equal to the original A_0 for all ops, overriding REQ-017.
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-020 Latency SHALL be fixed and independent of operand values: DONE_0 is high in the cycle after the 33rd enabled edge following the START-sampling edge.
REQ-021 BUSY_0 SHALL be high in CALC and FIN, and low in IDLE.
REQ-022 START_0 while BUSY_0=1 SHALL be ignored.
REQ-023 START_0 in the DONE_0 cycle SHALL be accepted (back-to-back).
REQ-024 With CE_0=0, the FSM, counter, datapath registers, P_0 and DONE_0 SHALL hold their values. A DONE_0 that is high SHALL stay high until the first enabled edge.
REQ-025 A_0, B_0 and OP_0 SHALL be don't-care outside the START-sampling edge.

Reset
REQ-026 An RSTN_0=0 edge SHALL force IDLE, BUSY_0=0, DONE_0=0, P_0=0 and a zero counter, regardless of CE_0.
REQ-027 Reset mid-operation SHALL abort the operation; no DONE_0 pulse SHALL follow.

Structure
REQ-028 A shared package SHALL hold:
- the OP encodings (DIV, DIVU, REM, REMU);
- the FSM state enum;
- the WIDTH default;
- the step count of 32.
REQ-029 The single sub-module SHALL be divider_step: a combinational shift/compare/subtract producing the next remainder and quotient bit.
REQ-030 The RTL SHALL contain no `/` or `%` operators.

Verification
REQ-031 DIVU: A=100, B=7, START one cycle -> BUSY_0 high for 33 cycles, then DONE_0 one cycle with P_0=14. REMU with the same operands -> P_0=2.
REQ-032 DIV: A=0xFFFFFFF9 (-7), B=2 -> P_0=0xFFFFFFFD. REM with the same operands -> P_0=0xFFFFFFFF.
REQ-033 Divide by zero, B=0:
- DIV A=5 -> 0xFFFFFFFF;
- DIV A=0xFFFFFFFB -> 0xFFFFFFFF;
- REMU A=5 -> 5;
- REM A=0xFFFFFFFB -> 0xFFFFFFFB.
REQ-034 Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-035 Handshake and CE_0 timing:
- START_0 at cycle 5 of a busy operation -> ignored, exactly one DONE_0;
- START_0 in the DONE_0 cycle -> second result 33 cycles later;
- CE_0 low 5 cycles mid-CALC -> DONE_0 at 38 cycles with the correct result.
REQ-036 RSTN_0 low on cycle 10 of an operation -> next edge shows BUSY_0=0 and P_0=0, with no DONE_0 in the following 40 cycles.
